// File: rtl/uart_tx_if.sv
// Host-side byte port of the buffered UART transmitter.
// Transfer rule: Tx_Byte is taken on a rising clock edge where Tx_Load=1 and Tx_Ready=1; a load with Tx_Ready=0 is dropped.
interface uart_tx_if;
    logic       Tx_Load;
    logic [7:0] Tx_Byte;
    logic       Tx_Ready;
    logic       Tx_Busy;
    logic       Tx_Done;

    modport master (
        output Tx_Load,
        output Tx_Byte,
        input  Tx_Ready,
        input  Tx_Busy,
        input  Tx_Done
    );

    modport slave (
        input  Tx_Load,
        input  Tx_Byte,
        output Tx_Ready,
        output Tx_Busy,
        output Tx_Done
    );
endinterface

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: small FIFO feeding a bit-serial framer, LSB first.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int CLKS_PER_BIT = 33,
    parameter int FIFO_AW      = 2
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    uart_tx_if.slave   host,
    output logic       o_Tx_Serial,
    output logic [2:0] dbg_state_o
);

    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [7:0]         CNT_MAX  = 8'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ready_q;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               serial_q, serial_d;
    logic               done_q, done_d;

    logic               push;
    logic               pop;
    logic               bit_end;

    // Ready is registered from the count, so a full FIFO refuses a push even while it is popping.
    assign push    = host.Tx_Load && ready_q;
    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= host.Tx_Byte;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;
        end
        case (state_q)
            ST_IDLE: begin
                serial_d = 1'b1;
                cnt_d    = 8'd0;
                if (count_q != '0) begin
                    pop      = 1'b1;
                    shift_d  = mem_q[rd_ptr_q];
                    serial_d = 1'b0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d  = ST_DATA;
                    serial_d = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d  = ST_PARITY;
                        serial_d = ^shift_q;
`else
                        state_d  = ST_STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        serial_d = shift_q[idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d  = ST_STOP;
                    serial_d = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                // Done lands on the first IDLE clock, the same clock Busy can fall.
                if (bit_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                serial_d = 1'b1;
                cnt_d    = 8'd0;
                idx_d    = 3'd0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= (count_d != FULL_CNT);
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign host.Tx_Ready = ready_q;
    assign host.Tx_Busy  = (state_q != ST_IDLE) || (count_q != '0);
    assign host.Tx_Done  = done_q;
    assign o_Tx_Serial   = serial_q;
    assign dbg_state_o   = state_q;

endmodule
